// File: rtl/aes_key_expand.sv
// AES-128 key schedule: iterative, one round key per clock into an 11-entry store; rd_key is registered (1 cycle).
// Key accepted in IDLE/READY when key_valid; key_ready low for the 10 expansion cycles, key_valid then ignored.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte of the packed table.
  logic [10:0] idx;
  assign idx = {~a_i, 3'b000};
  assign y_o = SBOX[idx +: 8];
endmodule

module aes_key_expand #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_WIDTH  = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key_in,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic                 keys_valid,
  input  logic [3:0]           rd_idx,
  output logic [KEY_WIDTH-1:0] rd_key,
  output logic                 busy
);
  if (NUM_ROUNDS != 10 || KEY_WIDTH != 128) begin : g_param_check
    $error("aes_key_expand supports only AES-128 (NUM_ROUNDS=10, KEY_WIDTH=128)");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t         state_q, state_d;
  logic           accept;
  logic [3:0]     cnt_q;
  logic [127:0]   work_q;
  logic [127:0]   store_q [0:10];
  logic [127:0]   rd_key_q;
  logic [127:0]   next_rk;
  logic [7:0]     rcon;
  logic [31:0]    p0, p1, p2, p3, rot, sub, t, w0, w1, w2, w3;

  always_comb begin
    rcon = 8'h00;
    case (cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign {p0, p1, p2, p3} = work_q;
  assign rot = {p3[23:0], p3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a_i(rot[8*b +: 8]), .y_o(sub[8*b +: 8]));
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign w0 = p0 ^ t;
  assign w1 = p1 ^ w0;
  assign w2 = p2 ^ w1;
  assign w3 = p3 ^ w2;
  assign next_rk = {w0, w1, w2, w3};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (key_valid) begin
          accept  = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (cnt_q == 4'd10) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 11; i++) store_q[i] <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      rd_key_q <= '0;
    end else begin
      if (accept) begin
        store_q[0] <= key_in;
        work_q     <= key_in;
        cnt_q      <= 4'd1;
      end else if (state_q == EXPAND) begin
        store_q[cnt_q] <= next_rk;
        work_q         <= next_rk;
        cnt_q          <= (cnt_q == 4'd10) ? 4'd0 : cnt_q + 4'd1;
      end
      // Reads see the store before this edge's write.
      rd_key_q <= (rd_idx <= 4'd10) ? store_q[rd_idx] : '0;
    end
  end

  assign key_ready  = (state_q != EXPAND);
  assign keys_valid = (state_q == READY);
  assign busy       = (state_q == EXPAND);
  assign rd_key     = rd_key_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 vectors and handshake/reset/read-port corner cases.
module tb_aes_key_expand;
  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         busy;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RK3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_RK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes_key_expand dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .keys_valid(keys_valid), .rd_idx(rd_idx),
    .rd_key(rd_key), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; key_in = '0; key_valid = 1'b0; rd_idx = '0;
    #12;
    check("rst_ready", 128'(key_ready), 128'd1);
    check("rst_kvalid", 128'(keys_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_rdkey", rd_key, '0);
    tick();
    reset = 1'b0;
    tick();

    // A.1 load with an ignored key pulse during expansion
    key_in = K1; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("exp_busy", 128'(busy), 128'd1);
    check("exp_ready", 128'(key_ready), 128'd0);
    for (int i = 1; i <= 10; i++) begin
      key_valid = (i == 3);
      key_in    = (i == 3) ? K2 : K1;
      tick();
      if (i == 3) check("exp_ready_pulse", 128'(key_ready), 128'd0);
      if (i == 9) check("kvalid_edge9", 128'(keys_valid), 128'd0);
    end
    key_valid = 1'b0;
    check("kvalid_edge10", 128'(keys_valid), 128'd1);
    check("ready_in_ready", 128'(key_ready), 128'd1);
    check("busy_in_ready", 128'(busy), 128'd0);

    rd_idx = 4'd1;  tick(); check("a1_rk1", rd_key, K1_RK1);
    rd_idx = 4'd10; tick(); check("a1_rk10", rd_key, K1_RK10);
    rd_idx = 4'd0;  tick(); check("a1_rk0", rd_key, K1);
    rd_idx = 4'd3;  tick(); check("a1_rk3", rd_key, K1_RK3);
    rd_idx = 4'd11; tick(); check("oor_11", rd_key, '0);
    rd_idx = 4'd15; tick(); check("oor_15", rd_key, '0);

    // Re-key from READY
    key_in = K2; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("rekey_kvalid_drop", 128'(keys_valid), 128'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 9) check("rekey_kvalid9", 128'(keys_valid), 128'd0);
    end
    check("rekey_kvalid10", 128'(keys_valid), 128'd1);
    rd_idx = 4'd10; tick(); check("c1_rk10", rd_key, K2_RK10);
    rd_idx = 4'd1;  tick(); check("c1_rk1", rd_key, K2_RK1);
    rd_idx = 4'd0;  tick(); check("c1_rk0", rd_key, K2);

    // Reset during expansion, key_valid held during reset
    key_in = K1; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    check("mid_busy", 128'(busy), 128'd1);
    reset = 1'b1; key_valid = 1'b1;
    #2;
    check("arst_kvalid", 128'(keys_valid), 128'd0);
    check("arst_ready", 128'(key_ready), 128'd1);
    check("arst_rdkey", rd_key, '0);
    tick();
    check("rst_no_accept", 128'(busy), 128'd0);
    key_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("post_rst_busy", 128'(busy), 128'd0);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      tick();
      check($sformatf("cleared_%0d", i), rd_key, '0);
    end

    // Reload A.1; read rk[3] across the edge that writes it
    rd_idx = 4'd3;
    key_in = K1; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
    tick();
    tick();
    check("rk3_same_cycle_old", rd_key, '0);
    tick();
    check("rk3_next_cycle_new", rd_key, K1_RK3);
    for (int i = 5; i <= 10; i++) tick();
    check("reload_kvalid", 128'(keys_valid), 128'd1);
    rd_idx = 4'd10; tick(); check("reload_rk10", rd_key, K1_RK10);
    rd_idx = 4'd1;  tick(); check("reload_rk1", rd_key, K1_RK1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
